// File: rtl/level_starter.sv
// Game level sequencer: a start request runs an optional 1 Hz countdown and then a level-begin pulse.
// Each newLevel request advances to the next level until the last level completes.
module level_starter #(
    parameter int NUM_LEVELS   = 8,
    parameter int LEVEL_W      = 3,
    parameter int PULSE_CYCLES = 4,
    parameter int COUNTDOWN_S  = 3,
    parameter int RESTART_EN   = 1
) (
    input  logic               Clk100M,
    input  logic               Reset,
    input  logic               Clk1Hz,
    input  logic               start,
    input  logic               newLevel,
    output logic               prelimSig,
    output logic [LEVEL_W-1:0] level,
    output logic [3:0]         secsLeft,
    output logic               started,
    output logic               gameDone
);

    localparam int                 CNT_W      = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(PULSE_CYCLES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [3:0]         SECS_INIT  = 4'(COUNTDOWN_S);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_PULSE,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 prelim_q, prelim_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [3:0]           secs_q, secs_d;
    logic                 started_q, started_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     pcnt_q, pcnt_d;

    logic start_prev_q, newlevel_prev_q;
    logic sync1_q, sync2_q, sync3_q;

    logic start_ev, newlevel_ev, tick, launch;

    assign start_ev    = start & ~start_prev_q;
    assign newlevel_ev = newLevel & ~newlevel_prev_q;
    // sync2_q is the synchronised Clk1Hz; sync3_q is its previous value for edge detection.
    assign tick        = sync2_q & ~sync3_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        prelim_d  = prelim_q;
        level_d   = level_q;
        secs_d    = secs_q;
        started_d = started_q;
        done_d    = done_q;
        pcnt_d    = pcnt_q;
        launch    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ev) begin
                    level_d   = '0;
                    started_d = 1'b1;
                    launch    = 1'b1;
                end
            end
            S_COUNT: begin
                if (tick) begin
                    if (secs_q == 4'd1) begin
                        secs_d  = 4'd0;
                        state_d = S_PULSE;
                    end else begin
                        secs_d = secs_q - 4'd1;
                    end
                end
            end
            S_PULSE: begin
                // The entry cycle is spent low; the pulse then stays high for PULSE_CYCLES cycles.
                if (pcnt_q == PULSE_LAST) begin
                    prelim_d = 1'b0;
                    pcnt_d   = '0;
                    state_d  = S_RUN;
                end else begin
                    prelim_d = 1'b1;
                    pcnt_d   = pcnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (newlevel_ev) begin
                    if (level_q == LAST_LEVEL) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        level_d = level_q + LEVEL_W'(1);
                        launch  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (start_ev && (RESTART_EN != 0)) begin
                    level_d   = '0;
                    started_d = 1'b1;
                    done_d    = 1'b0;
                    launch    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            secs_d  = SECS_INIT;
            state_d = (COUNTDOWN_S > 0) ? S_COUNT : S_PULSE;
        end
    end

    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            state_q         <= S_IDLE;
            prelim_q        <= 1'b0;
            level_q         <= '0;
            secs_q          <= '0;
            started_q       <= 1'b0;
            done_q          <= 1'b0;
            pcnt_q          <= '0;
            start_prev_q    <= 1'b0;
            newlevel_prev_q <= 1'b0;
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            sync3_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q         <= state_d;
            prelim_q        <= prelim_d;
            level_q         <= level_d;
            secs_q          <= secs_d;
            started_q       <= started_d;
            done_q          <= done_d;
            pcnt_q          <= pcnt_d;
            start_prev_q    <= start;
            newlevel_prev_q <= newLevel;
            sync1_q         <= Clk1Hz;
            sync2_q         <= sync1_q;
            sync3_q         <= sync2_q;
        end
    end

    assign prelimSig = prelim_q;
    assign level     = level_q;
    assign secsLeft  = secs_q;
    assign started   = started_q;
    assign gameDone  = done_q;

endmodule

// File: tb/tb_level_starter.sv
// Bench for level_starter: three parameterisations share stimulus; each is compared every cycle
// against a behavioural game model, plus directed literal checks of the key sequences.
module tb_level_starter;

    logic Clk100M = 1'b0;
    logic Reset   = 1'b1;
    logic Clk1Hz  = 1'b0;
    logic start   = 1'b0;
    logic newLevel = 1'b0;

    logic       a_prelim, b_prelim, c_prelim;
    logic [2:0] a_level, b_level;
    logic [1:0] c_level;
    logic [3:0] a_secs, b_secs, c_secs;
    logic       a_started, b_started, c_started;
    logic       a_done, b_done, c_done;

    int n_vec = 0;
    int n_err = 0;
    int pa_hi = 0;
    int pb_hi = 0;

    always #5 Clk100M = ~Clk100M;

    level_starter dut_a (
        .Clk100M(Clk100M), .Reset(Reset), .Clk1Hz(Clk1Hz), .start(start), .newLevel(newLevel),
        .prelimSig(a_prelim), .level(a_level), .secsLeft(a_secs), .started(a_started), .gameDone(a_done)
    );

    level_starter #(.COUNTDOWN_S(0)) dut_b (
        .Clk100M(Clk100M), .Reset(Reset), .Clk1Hz(Clk1Hz), .start(start), .newLevel(newLevel),
        .prelimSig(b_prelim), .level(b_level), .secsLeft(b_secs), .started(b_started), .gameDone(b_done)
    );

    level_starter #(.NUM_LEVELS(3), .LEVEL_W(2), .PULSE_CYCLES(1), .COUNTDOWN_S(2), .RESTART_EN(0)) dut_c (
        .Clk100M(Clk100M), .Reset(Reset), .Clk1Hz(Clk1Hz), .start(start), .newLevel(newLevel),
        .prelimSig(c_prelim), .level(c_level), .secsLeft(c_secs), .started(c_started), .gameDone(c_done)
    );

    // Game model: "pend" counts the remaining cycles of the pulse window (entry cycle included),
    // h holds the last three Clk1Hz samples, newest in h[0].
    typedef struct packed {
        bit       sp;
        bit       np;
        bit [2:0] h;
        bit       started;
        bit       done;
        bit       prelim;
        bit       counting;
        bit       running;
        int       level;
        int       secs;
        int       pend;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t mstep(input mdl_t m, input int nlev, input int pc, input int cd,
                                   input bit rs, input bit st, input bit nl, input bit hz);
        mdl_t n;
        bit sev, nev, tk, go;
        n   = m;
        sev = st & ~m.sp;
        nev = nl & ~m.np;
        tk  = m.h[1] & ~m.h[2];
        go  = 1'b0;
        n.sp = st;
        n.np = nl;
        n.h  = {m.h[1:0], hz};
        if (m.pend > 0) begin
            n.prelim  = (m.pend > 1);
            n.pend    = m.pend - 1;
            n.running = (n.pend == 0);
        end else if (m.counting) begin
            if (tk) begin
                n.secs = m.secs - 1;
                if (n.secs == 0) begin
                    n.counting = 1'b0;
                    n.pend     = pc + 1;
                end
            end
        end else if (m.running) begin
            if (nev) begin
                n.running = 1'b0;
                if (m.level < nlev - 1) begin
                    n.level = m.level + 1;
                    go      = 1'b1;
                end else begin
                    n.done = 1'b1;
                end
            end
        end else if (!m.started || (m.done && rs)) begin
            if (sev) begin
                n.level   = 0;
                n.started = 1'b1;
                n.done    = 1'b0;
                go        = 1'b1;
            end
        end
        if (go) begin
            n.secs = cd;
            if (cd > 0) n.counting = 1'b1;
            else        n.pend     = pc + 1;
        end
        return n;
    endfunction

    always @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            ma <= '0;
            mb <= '0;
            mc <= '0;
        end else begin
            ma <= mstep(ma, 8, 4, 3, 1'b1, start, newLevel, Clk1Hz);
            mb <= mstep(mb, 8, 4, 0, 1'b1, start, newLevel, Clk1Hz);
            mc <= mstep(mc, 3, 1, 2, 1'b0, start, newLevel, Clk1Hz);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string t, input logic pr, input int lv, input logic [3:0] sc,
                       input logic st, input logic gd, input mdl_t m);
        check({t, ".prelimSig"}, int'(pr), int'(m.prelim));
        check({t, ".level"},     lv,       m.level);
        check({t, ".secsLeft"},  int'(sc), m.secs);
        check({t, ".started"},   int'(st), int'(m.started));
        check({t, ".gameDone"},  int'(gd), int'(m.done));
    endtask

    // All waiting goes through here: sample at negedge+1, compare every DUT to its model.
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge Clk100M);
            #1;
            cmp("a", a_prelim, int'(a_level), a_secs, a_started, a_done, ma);
            cmp("b", b_prelim, int'(b_level), b_secs, b_started, b_done, mb);
            cmp("c", c_prelim, int'(c_level), c_secs, c_started, c_done, mc);
            pa_hi += int'(a_prelim);
            pb_hi += int'(b_prelim);
        end
    endtask

    task automatic tick1hz();
        Clk1Hz = 1'b1;
        run_cycles(5);
        Clk1Hz = 1'b0;
        run_cycles(5);
    endtask

    task automatic start_edge();
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        run_cycles(1);
    endtask

    task automatic nl_edge();
        newLevel = 1'b1;
        run_cycles(1);
        newLevel = 1'b0;
        run_cycles(1);
    endtask

    initial begin
        run_cycles(3);
        check("reset_prelim",  int'(a_prelim),  0);
        check("reset_level",   int'(a_level),   0);
        check("reset_secs",    int'(a_secs),    0);
        check("reset_started", int'(a_started), 0);
        check("reset_done",    int'(a_done),    0);
        Reset = 1'b0;
        run_cycles(2);

        // First game: countdown 3,2,1,0 on dut_a; immediate pulse on dut_b (no countdown).
        start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            run_cycles(1);
            if (i == 1) begin
                start = 1'b0;
                check("start_secs3",   int'(a_secs),    3);
                check("start_started", int'(a_started), 1);
                check("start_level0",  int'(a_level),   0);
                check("c_secs2",       int'(c_secs),    2);
            end
            check($sformatf("b_nocount_pulse_c%0d", i), int'(b_prelim), (i >= 2 && i <= 5) ? 1 : 0);
        end
        tick1hz();
        check("tick1_secs2", int'(a_secs), 2);
        tick1hz();
        check("tick2_secs1", int'(a_secs), 1);
        pa_hi = 0;
        tick1hz();
        run_cycles(5);
        check("tick3_secs0",     int'(a_secs),    0);
        check("pulse_width4",    pa_hi,           4);
        check("level0_after",    int'(a_level),   0);
        check("started_after",   int'(a_started), 1);
        check("prelim_low_run",  int'(a_prelim),  0);

        // Walk through all levels; the eighth newLevel ends the game without a pulse.
        for (int i = 1; i <= 8; i++) begin
            pa_hi = 0;
            nl_edge();
            check($sformatf("lvl_after_edge%0d", i), int'(a_level), (i < 8) ? i : 7);
            repeat (3) tick1hz();
            run_cycles(5);
            check($sformatf("lvl_pulse%0d", i), pa_hi, (i < 8) ? 4 : 0);
            check($sformatf("lvl_done%0d", i), int'(a_done), (i < 8) ? 0 : 1);
        end
        check("c_done_last",  int'(c_done),  1);
        check("c_level_last", int'(c_level), 2);

        // Restart from DONE: allowed on dut_a, ignored on dut_c.
        start_edge();
        check("restart_level", int'(a_level), 0);
        check("restart_done",  int'(a_done),  0);
        check("restart_secs",  int'(a_secs),  3);
        check("norestart_done",  int'(c_done),  1);
        check("norestart_level", int'(c_level), 2);

        // newLevel during COUNT and during PULSE is dropped.
        nl_edge();
        check("nl_in_count_level", int'(a_level), 0);
        check("nl_in_count_secs",  int'(a_secs),  3);
        tick1hz();
        tick1hz();
        pa_hi = 0;
        Clk1Hz = 1'b1;
        run_cycles(3);
        newLevel = 1'b1;
        run_cycles(1);
        newLevel = 1'b0;
        run_cycles(8);
        Clk1Hz = 1'b0;
        run_cycles(5);
        check("nl_in_pulse_level", int'(a_level), 0);
        check("nl_in_pulse_width", pa_hi,         4);

        // start and newLevel together in IDLE: one sequence at level 0.
        Reset = 1'b1;
        run_cycles(2);
        Reset = 1'b0;
        run_cycles(1);
        start    = 1'b1;
        newLevel = 1'b1;
        run_cycles(1);
        start    = 1'b0;
        newLevel = 1'b0;
        run_cycles(1);
        check("both_level0", int'(a_level), 0);
        check("both_secs3",  int'(a_secs),  3);
        pa_hi = 0;
        repeat (3) tick1hz();
        run_cycles(5);
        check("both_one_pulse", pa_hi,         4);
        check("both_level_end", int'(a_level), 0);

        // Reset in the middle of dut_b's pulse, with start held high through release.
        Reset = 1'b1;
        run_cycles(2);
        Reset = 1'b0;
        run_cycles(2);
        start = 1'b1;
        run_cycles(2);
        check("b_pulse_cycle2", int'(b_prelim), 1);
        #1;
        Reset = 1'b1;
        #1;
        check("rst_prelim_now",  int'(b_prelim),  0);
        check("rst_level_now",   int'(b_level),   0);
        check("rst_secs_now",    int'(b_secs),    0);
        check("rst_started_now", int'(b_started), 0);
        check("rst_done_now",    int'(b_done),    0);
        run_cycles(3);
        pb_hi = 0;
        Reset = 1'b0;
        run_cycles(20);
        check("held_start_one_pulse", pb_hi, 4);
        check("held_start_started",   int'(b_started), 1);
        start = 1'b0;
        run_cycles(2);

        // Randomised traffic, including occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 19) == 0);
            newLevel = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) Clk1Hz = ~Clk1Hz;
            Reset    = ($urandom_range(0, 399) == 0);
            run_cycles(1);
        end
        Reset = 1'b0;
        run_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
